// File: rtl/seq_right_shifter_pkg.sv
// Shared constants and state encoding for the
// multi-cycle right shifter.
package seq_right_shifter_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int SHAMT_WIDTH = 5;
    localparam int BIG_STEP    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_right_shifter_if.sv
// Start/busy/done handshake and operand bus
// between the ALU controller and the shifter.
interface seq_right_shifter_if;
    import seq_right_shifter_pkg::*;

    logic                   start;
    logic                   arith;
    logic [DATA_WIDTH-1:0]  data_in;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   busy;
    logic                   done;
    logic [DATA_WIDTH-1:0]  result_out;

    modport master (
        output start,
        output arith,
        output data_in,
        output shamt,
        input  busy,
        input  done,
        input  result_out
    );

    modport slave (
        input  start,
        input  arith,
        input  data_in,
        input  shamt,
        output busy,
        output done,
        output result_out
    );

endinterface

// File: rtl/right_shift_step.sv
// One combinational step: shift right by BIG_STEP
// or by one, replicating the fill bit.
module right_shift_step #(
    parameter int DATA_WIDTH = 32,
    parameter int BIG_STEP   = 4
) (
    input  logic [DATA_WIDTH-1:0] i_value,
    input  logic                  i_fill,
    input  logic                  i_big,
    output logic [DATA_WIDTH-1:0] o_value
);

    logic [DATA_WIDTH-1:0] w_big_val;
    logic [DATA_WIDTH-1:0] w_one_val;
    logic                  w_unused_lsb;

    assign w_big_val = {{BIG_STEP{i_fill}},
                        i_value[DATA_WIDTH-1:BIG_STEP]};
    assign w_one_val = {i_fill, i_value[DATA_WIDTH-1:1]};

    // bit 0 always falls off the end
    assign w_unused_lsb = i_value[0];

    assign o_value = i_big ? w_big_val : w_one_val;

endmodule

// File: rtl/seq_right_shifter.sv
// Multi-cycle SRL/SRA shifter: big steps while the
// remaining count allows, then single-bit steps.
import seq_right_shifter_pkg::*;

module seq_right_shifter (
    input logic              Clk,
    input logic              Reset,
    seq_right_shifter_if.slave bus
);

    state_t                 r_state;
    logic [DATA_WIDTH-1:0]  r_work;
    logic [SHAMT_WIDTH-1:0] r_rem;
    logic                   r_fill;
    logic [DATA_WIDTH-1:0]  r_result;
    logic                   r_done;
    logic                   r_busy;

    logic                   w_big;
    logic [SHAMT_WIDTH-1:0] w_dec;
    logic [DATA_WIDTH-1:0]  w_next_work;

    assign w_big = (r_rem >= SHAMT_WIDTH'(BIG_STEP));
    assign w_dec = w_big ? SHAMT_WIDTH'(BIG_STEP)
                         : SHAMT_WIDTH'(1);

    right_shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .BIG_STEP   (BIG_STEP)
    ) u_step (
        .i_value (r_work),
        .i_fill  (r_fill),
        .i_big   (w_big),
        .o_value (w_next_work)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_work   <= '0;
            r_rem    <= '0;
            r_fill   <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_work  <= bus.data_in;
                        r_rem   <= bus.shamt;
                        r_fill  <= bus.arith &
                                   bus.data_in[DATA_WIDTH-1];
                        r_state <= SHIFT;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (r_rem == '0) begin
                        r_result <= r_work;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_work <= w_next_work;
                        r_rem  <= r_rem - w_dec;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.result_out = r_result;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed bench for seq_right_shifter with
// hand-computed results and latencies.
module tb_seq_right_shifter;

    logic Clk;
    logic Reset;
    int   tests;
    int   failed;
    logic [31:0] last_result;
    int   dones;

    seq_right_shifter_if bus();

    seq_right_shifter dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h expected %h",
                   tag, obs, exp);
        end
    endtask

    // start sampled at edge 0; done visible after edge lat
    task automatic run_op(input string tag,
                          input logic [31:0] d,
                          input logic [4:0] s,
                          input logic a,
                          input logic [31:0] exp,
                          input int lat);
        bus.start = 1'b1;
        bus.data_in = d;
        bus.shamt = s;
        bus.arith = a;
        tick();
        bus.start = 1'b0;
        bus.data_in = ~d;
        bus.shamt = ~s;
        bus.arith = ~a;
        chk({tag, "/busy0"}, {31'b0, bus.busy}, 32'd1);
        for (int e = 1; e < lat; e++) begin
            tick();
            chk({tag, "/busy"}, {31'b0, bus.busy}, 32'd1);
            chk({tag, "/nodone"}, {31'b0, bus.done}, 32'd0);
            chk({tag, "/hold"}, bus.result_out, last_result);
        end
        tick();
        chk({tag, "/done"}, {31'b0, bus.done}, 32'd1);
        chk({tag, "/res"}, bus.result_out, exp);
        chk({tag, "/busyd"}, {31'b0, bus.busy}, 32'd1);
        tick();
        chk({tag, "/done0"}, {31'b0, bus.done}, 32'd0);
        chk({tag, "/idle"}, {31'b0, bus.busy}, 32'd0);
        chk({tag, "/keep"}, bus.result_out, exp);
        last_result = exp;
    endtask

    initial begin
        tests = 0;
        failed = 0;
        last_result = 32'h0;
        bus.start = 1'b0;
        bus.arith = 1'b0;
        bus.data_in = 32'h0;
        bus.shamt = 5'd0;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        chk("rst/busy", {31'b0, bus.busy}, 32'd0);
        chk("rst/done", {31'b0, bus.done}, 32'd0);
        chk("rst/res", bus.result_out, 32'h0);
        tick();

        run_op("srl7", 32'h80000000, 5'd7, 1'b0,
               32'h01000000, 5);
        run_op("sra7", 32'h80000000, 5'd7, 1'b1,
               32'hFF000000, 5);
        run_op("sra4pos", 32'h7FFFFFF0, 5'd4, 1'b1,
               32'h07FFFFFF, 2);
        run_op("sh0", 32'hDEADBEEF, 5'd0, 1'b0,
               32'hDEADBEEF, 1);
        run_op("srl5", 32'hF0000000, 5'd5, 1'b0,
               32'h07800000, 3);
        run_op("sra3", 32'h80000000, 5'd3, 1'b1,
               32'hF0000000, 4);
        run_op("srl31", 32'hFFFFFFFF, 5'd31, 1'b0,
               32'h00000001, 11);
        run_op("sra31", 32'hFFFFFFFF, 5'd31, 1'b1,
               32'hFFFFFFFF, 11);

        // collision: start pokes on edges 3, 11, 12
        bus.start = 1'b1;
        bus.data_in = 32'h80000000;
        bus.shamt = 5'd31;
        bus.arith = 1'b0;
        tick();
        dones = 0;
        for (int e = 1; e <= 14; e++) begin
            bus.start = (e == 3 || e == 11 || e == 12);
            bus.data_in = 32'h12345678;
            bus.shamt = 5'd1;
            tick();
            if (bus.done === 1'b1) dones++;
            if (e == 11) begin
                chk("coll/done11", {31'b0, bus.done}, 32'd1);
                chk("coll/res", bus.result_out, 32'h1);
            end
        end
        bus.start = 1'b0;
        chk("coll/dones", dones, 32'd1);
        chk("coll/idle", {31'b0, bus.busy}, 32'd0);
        chk("coll/keep", bus.result_out, 32'h1);
        last_result = 32'h1;

        // asynchronous reset between edges 4 and 5
        bus.start = 1'b1;
        bus.data_in = 32'hFFFFFFFF;
        bus.shamt = 5'd20;
        bus.arith = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        #2 Reset = 1'b1;
        #1;
        chk("arst/busy", {31'b0, bus.busy}, 32'd0);
        chk("arst/done", {31'b0, bus.done}, 32'd0);
        chk("arst/res", bus.result_out, 32'h0);
        tick();
        Reset = 1'b0;
        dones = 0;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        chk("arst/nodone", dones, 32'd0);
        chk("arst/idle", {31'b0, bus.busy}, 32'd0);
        last_result = 32'h0;
        run_op("post", 32'h00000100, 5'd8, 1'b0,
               32'h00000001, 3);

        // back-to-back: accepts at edges 0, 6, 10
        bus.start = 1'b1;
        bus.data_in = 32'h0000F000;
        bus.shamt = 5'd12;
        bus.arith = 1'b0;
        tick();
        bus.data_in = 32'h80000000;
        bus.shamt = 5'd1;
        bus.arith = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            if (e == 7) begin
                bus.data_in = 32'h12345678;
                bus.shamt = 5'd0;
                bus.arith = 1'b0;
            end
            if (e == 11) bus.start = 1'b0;
            tick();
            if (e == 4) begin
                chk("b2b/d1", {31'b0, bus.done}, 32'd1);
                chk("b2b/r1", bus.result_out, 32'h0000000F);
            end else if (e == 8) begin
                chk("b2b/d2", {31'b0, bus.done}, 32'd1);
                chk("b2b/r2", bus.result_out, 32'hC0000000);
            end else if (e == 11) begin
                chk("b2b/d3", {31'b0, bus.done}, 32'd1);
                chk("b2b/r3", bus.result_out, 32'h12345678);
            end else begin
                chk("b2b/nod", {31'b0, bus.done}, 32'd0);
            end
        end
        chk("b2b/idle", {31'b0, bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed",
                 tests, failed);
        $finish;
    end

endmodule
